// File: rtl/add_share_arb.sv
// Round-robin arbiter that time-shares one registered W-bit adder among N requesters.
// Captures one operand pair at a time, executes it for LAT cycles, and returns a tagged W+1-bit sum.
module add_share_arb #(
  parameter int unsigned N   = 4,
  parameter int unsigned W   = 8,
  parameter int unsigned LAT = 2,
  parameter int unsigned IDW = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   a,
  input  logic [N*W-1:0]   b,
  output logic [N-1:0]     gnt,
  output logic             busy,
  output logic [W:0]       res,
  output logic [IDW-1:0]   res_id,
  output logic             res_valid
);

  localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] id;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;

  logic [IDW-1:0] win;
  logic [IDW-1:0] hi_idx;
  logic [IDW-1:0] lo_idx;
  logic           hi_vld;
  logic           lo_vld;
  logic           found;
  logic [W-1:0]   sel_a;
  logic [W-1:0]   sel_b;

  // Round-robin pick: lowest requester at or above ptr, else lowest overall (wrap).
  always_comb begin
    hi_idx = '0;
    lo_idx = '0;
    hi_vld = 1'b0;
    lo_vld = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_idx = IDW'(i);
        lo_vld = 1'b1;
        if (IDW'(i) >= ptr) begin
          hi_idx = IDW'(i);
          hi_vld = 1'b1;
        end
      end
    end
    found = lo_vld;
    win   = hi_vld ? hi_idx : lo_idx;
  end

  // Operand mux for the current winner.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (IDW'(i) == win) begin
        sel_a = a[i*W +: W];
        sel_b = b[i*W +: W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      id        <= '0;
      cnt       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      gnt       <= '0;
      busy      <= 1'b0;
      res       <= '0;
      res_id    <= '0;
      res_valid <= 1'b0;
    end else begin
      gnt       <= '0;
      res_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            op_a  <= sel_a;
            op_b  <= sel_b;
            id    <= win;
            ptr   <= (win == IDW'(N - 1)) ? '0 : win + 1'b1;
            cnt   <= CW'(LAT - 1);
            gnt   <= N'(1) << win;
            busy  <= 1'b1;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            res       <= {1'b0, op_a} + {1'b0, op_b};
            res_id    <= id;
            res_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add_share_arb.sv
// Scoreboard bench for add_share_arb: a LAT=2 instance for arbitration/reset tests,
// and a LAT=1 instance for the maximum-sum case.
module tb_add_share_arb;

  localparam int unsigned N = 4;
  localparam int unsigned W = 8;

  typedef struct {
    int id;
    int res;
    int cyc;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req0, req1;
  logic [N*W-1:0] a0, b0, a1, b1;
  logic [N-1:0]   gnt0, gnt1;
  logic           busy0, busy1;
  logic [W:0]     res0, res1;
  logic [1:0]     id0, id1;
  logic           rv0, rv1;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  add_share_arb #(.N(N), .W(W), .LAT(2)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .a(a0), .b(b0),
    .gnt(gnt0), .busy(busy0), .res(res0), .res_id(id0), .res_valid(rv0)
  );

  add_share_arb #(.N(N), .W(W), .LAT(1)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .a(a1), .b(b1),
    .gnt(gnt1), .busy(busy1), .res(res1), .res_id(id1), .res_valid(rv1)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Wait (bounded) for a grant, check it, and queue the expected result for the monitor.
  task automatic wait_gnt(input int dut, input int exp_idx, input int exp_res, input bit push,
                          output int gcyc);
    logic [N-1:0] g;
    int           lat;
    exp_t         e;
    g = '0;
    for (int t = 0; t < 12; t++) begin
      tick();
      g = (dut == 0) ? gnt0 : gnt1;
      if (g != '0) break;
    end
    gcyc = cyc;
    if (g == '0) begin
      total++;
      bad++;
      $display("FAIL gnt_timeout dut%0d: got none want idx %0d", dut, exp_idx);
    end else begin
      chk($sformatf("gnt dut%0d", dut), int'(g), 1 << exp_idx);
    end
    if (push) begin
      lat   = (dut == 0) ? 2 : 1;
      e.id  = exp_idx;
      e.res = exp_res;
      e.cyc = gcyc + lat;
      if (dut == 0) q0.push_back(e);
      else          q1.push_back(e);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Monitors: pop and compare whenever a result is presented.
  always @(negedge clk) begin
    exp_t e;
    if (rv0) begin
      if (q0.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid dut0: got res %0h id %0d want none", res0, id0);
      end else begin
        e = q0.pop_front();
        chk("res dut0", int'(res0), e.res);
        chk("res_id dut0", int'(id0), e.id);
        chk("valid_cycle dut0", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rv1) begin
      if (q1.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid dut1: got res %0h id %0d want none", res1, id1);
      end else begin
        e = q1.pop_front();
        chk("res dut1", int'(res1), e.res);
        chk("res_id dut1", int'(id1), e.id);
        chk("valid_cycle dut1", cyc, e.cyc);
      end
    end
  end

  initial begin
    int gc;
    int prev;
    rst  = 1'b1;
    req0 = '0;
    req1 = '0;
    a0   = '0;
    b0   = '0;
    a1   = '0;
    b1   = '0;
    tick();
    do_reset();

    // Reset state
    chk("rst gnt", int'(gnt0), 0);
    chk("rst busy", int'(busy0), 0);
    chk("rst res", int'(res0), 0);
    chk("rst res_id", int'(id0), 0);
    chk("rst res_valid", int'(rv0), 0);

    // Single op: FF + 01 on requester 0
    a0[7:0] = 8'hFF;
    b0[7:0] = 8'h01;
    req0    = 4'b0001;
    wait_gnt(0, 0, 'h100, 1'b1, gc);
    chk("single busy c1", int'(busy0), 1);
    req0 = '0;
    tick();
    chk("single gnt pulse", int'(gnt0), 0);
    chk("single busy c2", int'(busy0), 1);
    tick();
    chk("single busy c3", int'(busy0), 1);
    tick();
    chk("single busy c4", int'(busy0), 0);

    // Round-robin with all requests held: grants 0,1,2,3,0 every 4 cycles
    do_reset();
    for (int i = 0; i < int'(N); i++) begin
      a0[i*W +: W] = 8'(i);
      b0[i*W +: W] = 8'h10;
    end
    req0 = 4'b1111;
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(0, k % 4, 'h10 + (k % 4), 1'b1, gc);
      if (k > 0) chk("rr spacing", gc - prev, 4);
      prev = gc;
    end
    req0 = 4'b0010;

    // Pointer skip: grant 1 (ptr=2), then 0011 -> 0 (wrap), then ptr=1 -> 1
    wait_gnt(0, 1, 'h11, 1'b1, gc);
    req0 = 4'b0011;
    wait_gnt(0, 0, 'h10, 1'b1, gc);
    wait_gnt(0, 1, 'h11, 1'b1, gc);
    req0 = 4'b0001;

    // Busy ignore: req[2] raised during EXEC of requester 0
    wait_gnt(0, 0, 'h10, 1'b1, gc);
    req0 = 4'b0100;
    tick();
    chk("busy ignore exec", int'(gnt0), 0);
    tick();
    chk("busy ignore done", int'(gnt0), 0);
    tick();
    chk("busy ignore idle gnt", int'(gnt0), 0);
    chk("busy ignore idle busy", int'(busy0), 0);
    wait_gnt(0, 2, 'h12, 1'b1, gc);
    req0 = '0;
    repeat (4) tick();

    // Reset mid-op: requester 3 captured, reset in its second EXEC cycle
    req0 = 4'b1000;
    wait_gnt(0, 3, 0, 1'b0, gc);
    req0 = '0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst gnt", int'(gnt0), 0);
    chk("midrst busy", int'(busy0), 0);
    chk("midrst res", int'(res0), 0);
    chk("midrst res_id", int'(id0), 0);
    chk("midrst res_valid", int'(rv0), 0);
    for (int t = 0; t < 4; t++) begin
      tick();
      chk("midrst no valid", int'(rv0), 0);
    end
    req0 = 4'b0100;
    wait_gnt(0, 2, 'h12, 1'b1, gc);
    req0 = '0;

    // Max sum on LAT=1 instance, then a zero sum
    a1[31:24] = 8'hFF;
    b1[31:24] = 8'hFF;
    req1      = 4'b1000;
    wait_gnt(1, 3, 'h1FE, 1'b1, gc);
    req1 = 4'b0001;
    wait_gnt(1, 0, 'h000, 1'b1, gc);
    req1 = '0;

    repeat (6) tick();
    chk("dut0 queue drained", q0.size(), 0);
    chk("dut1 queue drained", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/add_share_arb.md
# add_share_arb

Round-robin arbiter and sequencer that shares one registered W-bit adder, the `O <= a + b` style datapath, among N requesters. Each requester presents an operand pair under a req/gnt handshake. The block captures one pair at a time, runs it through the adder for LAT cycles, and returns a tagged result. It sits between the requesting blocks and the single shared adder resource.

## Interface
Parameters:
- N, 4, number of requesters (2..8)
- W, 8, operand width
- LAT, 2, execution cycles of the shared adder (>=1)
- IDW, $clog2(N), requester-ID width

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous and active-high (one clock; reset is synchronous and active-high)
- req  in  N  per-requester request; bit i held high until gnt[i] seen
- a  in  N*W  operand A, requester i at bits [i*W +: W]; stable while req[i] high
- b  in  N*W  operand B, same packing as a
- gnt  out  N  one-hot, registered one-cycle pulse: operands of requester i captured
- busy  out  1  high in EXEC and DONE
- res  out  W+1  sum a+b, zero-extended, carry in MSB
- res_id  out  IDW  index of requester owning res
- res_valid  out  1  one-cycle pulse, res/res_id valid

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - If req is nonzero, pick winner k by round-robin. Search indices ptr, ptr+1, … mod N and take the first with req set.
  - On that edge: latch a_k, b_k and k; set ptr = (k+1) mod N; load cnt = LAT-1; go to EXEC.
  - If req is zero, stay in IDLE.
- EXEC:
  - gnt[k] = 1 in the first EXEC cycle only.
  - Decrement cnt each cycle. When cnt == 0, register res = {1'b0,a}+{1'b0,b} and res_id = k, then go to DONE.
- DONE: res_valid = 1 for exactly one cycle, then go to IDLE.
- res and res_id hold their value until the next DONE. res_valid is the only qualifier.
- req is ignored outside IDLE. No new capture can happen while busy.
- Requester obligation: drop req[k] on the edge after seeing gnt[k], and re-raise it no earlier than the next cycle.
  - A requester that keeps req high is treated as a new request at the next IDLE. This is legal back-to-back use.
- Arithmetic: the full W+1-bit sum. Overflow is impossible. Example: FF+FF = 1FE.
- A req bit that deasserts while in IDLE before capture has no effect. Only req sampled at the capture edge counts.
- Reset values: state IDLE, ptr 0, cnt 0, gnt 0, busy 0, res 0, res_id 0, res_valid 0.
- Reset mid-operation:
  - The in-flight op is discarded and no res_valid is produced for it.
  - A gnt already given is not repeated. The requester must re-request if it needs the op.

## Timing
- Edge T0: capture in IDLE.
- Cycles T0+1 .. T0+LAT: EXEC; gnt pulse in cycle T0+1; busy high.
- Cycle T0+LAT+1: DONE; res_valid high; busy high.
- Cycle T0+LAT+2: IDLE; busy low. The next capture can occur at this edge.
- Latency from capture to res_valid: LAT+1 cycles.
- Peak throughput: one op per LAT+2 cycles.
- gnt, busy, res, res_id and res_valid are all registered. There are no combinational paths from inputs to outputs.

## Test plan
- **Single op** (N=4, W=8, LAT=2): after reset, req=0001, a0=FF, b0=01.
  - gnt=0001 one cycle after capture.
  - res_valid 3 cycles after capture, with res=100 and res_id=0.
  - busy is high for 3 cycles.
- **Round-robin fairness:** req=1111 held continuously, with distinct operands per requester (ai=i, bi=10).
  - Grants go 0,1,2,3,0.
  - Results 10,11,12,13,10 appear in the same order, one every 4 cycles.
- **Pointer skip:** after a grant to 1, req=0011.
  - The next grant goes to 0, because ptr=2 and the search wraps past 2 and 3.
  - ptr then becomes 1.
- **Busy ignore:** raise req[2] during EXEC of requester 0.
  - No gnt[2] while busy.
  - gnt[2] follows the capture made in the next IDLE.
- **Reset mid-op:** assert rst for one cycle in the second EXEC cycle.
  - No res_valid appears.
  - All outputs are 0 the cycle after reset.
  - The next req=0100 is granted to 2.
- **Max sum:** a=FF, b=FF on requester 3, LAT=1.
  - res=1FE and res_id=3.
  - res_valid 2 cycles after capture.
